// File: rtl/placar_pontuacao.sv
// placar_pontuacao: per-team saturating score accumulator.
// Raw buttons are synchronised and edge-detected. Each rising edge becomes one event.
// In any cycle, only the highest-priority event is applied to a 7-bit score
// with depth-1 undo.
module placar_pontuacao #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_SCORE   = 127
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic       btn_p3,
  input  logic       btn_undo,
  input  logic       btn_clear,
  output logic [6:0] score,
  output logic       atualizado,
  output logic       saturado
);

  localparam int NB = 5;
  localparam logic [7:0] MAX8 = 8'(MAX_SCORE);
  localparam logic [6:0] MAX7 = 7'(MAX_SCORE);

  // bit order: {clear, undo, p3, p2, p1}
  logic [NB-1:0]                  btn_raw;
  logic [SYNC_STAGES-1:0][NB-1:0] sync_q;
  logic [NB-1:0]                  prev_q;
  logic [NB-1:0]                  evt;

  logic [6:0] score_q, score_d;
  logic [1:0] last_add_q, last_add_d;
  logic       sat_q, sat_d;
  logic       upd_q, upd_d;

  logic [1:0] add_k;
  logic [7:0] sum;

  assign btn_raw = {btn_clear, btn_undo, btn_p3, btn_p2, btn_p1};
  assign evt     = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Synchroniser chain per button plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Amount requested by the highest-priority add event (0 when none)
  always_comb begin
    add_k = 2'd0;
    if (evt[2])      add_k = 2'd3;
    else if (evt[1]) add_k = 2'd2;
    else if (evt[0]) add_k = 2'd1;
  end

  // The sum is computed one bit wider so it cannot wrap before the saturation test.
  assign sum = {1'b0, score_q} + {6'd0, add_k};

  // Next-state for score, undo history and flags; clear > undo > p3 > p2 > p1
  always_comb begin
    score_d    = score_q;
    last_add_d = last_add_q;
    sat_d      = sat_q;
    upd_d      = 1'b0;
    if (evt[4]) begin
      score_d    = '0;
      last_add_d = '0;
      sat_d      = 1'b0;
      upd_d      = 1'b1;
    end else if (evt[3]) begin
      if (last_add_q != 2'd0) begin
        score_d    = score_q - {5'd0, last_add_q};
        last_add_d = '0;
        sat_d      = 1'b0;
        upd_d      = 1'b1;
      end
    end else if (add_k != 2'd0) begin
      if (sum <= MAX8) begin
        score_d    = sum[6:0];
        last_add_d = add_k;
        sat_d      = 1'b0;
        upd_d      = 1'b1;
      end else begin
        // The headroom is less than add_k here, so it fits in two bits.
        last_add_d = 2'(MAX8 - {1'b0, score_q});
        score_d    = MAX7;
        sat_d      = 1'b1;
        upd_d      = (score_q != MAX7);
      end
    end
  end

  // Registered score state and output flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q    <= '0;
      last_add_q <= '0;
      sat_q      <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      score_q    <= score_d;
      last_add_q <= last_add_d;
      sat_q      <= sat_d;
      upd_q      <= upd_d;
    end
  end

  assign score      = score_q;
  assign atualizado = upd_q;
  assign saturado   = sat_q;

endmodule

// File: tb/tb_placar_pontuacao.sv
// Scoreboard bench for placar_pontuacao.
// The driver turns raw button levels into expected updates, each tagged with the clock edge at which it must appear.
// The monitor checks the outputs every cycle against those expectations.
module tb_placar_pontuacao;

  localparam int SYNC = 2;
  localparam int MAX  = 127;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_p1, btn_p2, btn_p3, btn_undo, btn_clear;
  logic [6:0] score;
  logic       atualizado, saturado;

  placar_pontuacao #(.SYNC_STAGES(SYNC), .MAX_SCORE(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_p1(btn_p1), .btn_p2(btn_p2), .btn_p3(btn_p3),
    .btn_undo(btn_undo), .btn_clear(btn_clear),
    .score(score), .atualizado(atualizado), .saturado(saturado)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int e;
    int sc;
    bit sat;
    bit upd;
  } exp_t;
  exp_t q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state
  int         m_sc = 0;
  int         m_la = 0;
  bit         m_sat = 0;
  logic [4:0] prev_m = '0;

  // values the monitor expects to see on the outputs
  int shown_sc = 0;
  bit shown_sat = 0;

  task automatic check(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Button level m (bits {clear,undo,p3,p2,p1}) is sampled at edge e_samp.
  // Any resulting action becomes visible after edge e_samp+SYNC.
  task automatic model_sample(input logic [4:0] m, input int e_vis);
    logic [4:0] rise;
    int k;
    bit upd;
    rise   = m & ~prev_m;
    prev_m = m;
    if (rise == 5'd0) return;
    upd = 0;
    if (rise[4]) begin
      m_sc = 0; m_la = 0; m_sat = 0; upd = 1;
    end else if (rise[3]) begin
      if (m_la != 0) begin
        m_sc = m_sc - m_la; m_la = 0; m_sat = 0; upd = 1;
      end
    end else begin
      k = rise[2] ? 3 : (rise[1] ? 2 : 1);
      if (m_sc + k <= MAX) begin
        m_sc = m_sc + k; m_la = k; m_sat = 0; upd = 1;
      end else begin
        upd   = (m_sc != MAX);
        m_la  = MAX - m_sc;
        m_sc  = MAX;
        m_sat = 1;
      end
    end
    q.push_back('{e: e_vis, sc: m_sc, sat: m_sat, upd: upd});
  endtask

  task automatic cyc(input logic [4:0] m);
    @(negedge clk);
    {btn_clear, btn_undo, btn_p3, btn_p2, btn_p1} = m;
    if (rst_n) model_sample(m, edge_cnt + 1 + SYNC);
    else prev_m = '0;
  endtask

  task automatic press(input logic [4:0] m);
    cyc(m);
    cyc(5'd0);
  endtask

  // Monitor: checks outputs each cycle against the expectation scheduled for that edge
  always @(negedge clk) begin
    bit   exp_upd;
    exp_t x;
    exp_upd = 0;
    if (!rst_n) begin
      check("reset_score", int'(score), 0);
      check("reset_flags", int'({atualizado, saturado}), 0);
      shown_sc  = 0;
      shown_sat = 0;
    end else begin
      while (q.size() > 0 && q[0].e < edge_cnt) begin
        check("update_missed_edge", edge_cnt, q[0].e);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].e == edge_cnt) begin
        x         = q.pop_front();
        shown_sc  = x.sc;
        shown_sat = x.sat;
        exp_upd   = x.upd;
      end
      check("atualizado", int'(atualizado), int'(exp_upd));
      check("score", int'(score), shown_sc);
      check("saturado", int'(saturado), int'(shown_sat));
    end
  end

  initial begin
    int r, hi, lo;
    logic [4:0] m;
    rst_n = 1'b0;
    {btn_clear, btn_undo, btn_p3, btn_p2, btn_p1} = '0;
    repeat (3) cyc(5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // p2 held for five cycles: one update only
    repeat (5) cyc(5'b00010);
    repeat (3) cyc(5'd0);

    // p3, p1, undo, undo from zero
    press(5'b10000);
    press(5'b00100); press(5'b00001); press(5'b01000); press(5'b01000);
    repeat (2) cyc(5'd0);

    // saturation from 125: p3, p3, undo
    press(5'b10000);
    repeat (41) press(5'b00100);
    press(5'b00010);
    press(5'b00100); press(5'b00100); press(5'b01000);

    // saturation from 125 then undo back
    press(5'b10000);
    repeat (41) press(5'b00100);
    press(5'b00010);
    press(5'b00100); press(5'b01000);

    // clear/undo/p3 simultaneous at 40, then undo
    press(5'b10000);
    repeat (13) press(5'b00100);
    press(5'b00001);
    press(5'b11100);
    repeat (2) cyc(5'd0);
    press(5'b01000);

    // async reset while p1 is in the synchroniser at score 10
    press(5'b10000);
    repeat (3) press(5'b00100);
    press(5'b00001);
    repeat (3) cyc(5'd0);
    cyc(5'b00001);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    m_sc = 0; m_la = 0; m_sat = 0; prev_m = '0;
    #1;
    check("async_reset_score", int'(score), 0);
    check("async_reset_flags", int'({atualizado, saturado}), 0);
    repeat (3) cyc(5'b00001);
    @(negedge clk);
    rst_n = 1'b1;
    model_sample(5'b00001, edge_cnt + 1 + SYNC);
    repeat (4) cyc(5'b00001);
    repeat (3) cyc(5'd0);

    // randomized presses, overlaps and bursts toward saturation
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 19);
      if (r == 19) begin
        repeat ($urandom_range(20, 45)) press(5'b00100);
      end else begin
        if (r == 0)       m = 5'b10000;
        else if (r <= 3)  m = 5'b01000;
        else if (r <= 15) m = 5'($urandom_range(1, 7));
        else              m = 5'($urandom_range(0, 31));
        hi = $urandom_range(1, 3);
        lo = $urandom_range(0, 2);
        repeat (hi) cyc(m);
        repeat (lo) cyc(5'd0);
      end
    end

    repeat (8) cyc(5'd0);
    check("queue_drained", q.size(), 0);
    check("final_score", int'(score), m_sc);
    check("final_saturado", int'(saturado), int'(m_sat));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
